idecode: RTL
============

IDECODE -- requirements
Module: idecode

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 32, PC/address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, instruction/register data width.
REQ-003 SHALL have parameter REG_ADDR_BITS, default 5, register index width.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port enable  input  1  global step; low freezes all state, including register-file writes.
REQ-007 SHALL have port instr_in  input  DATA_WIDTH  instruction from the fetch stage.
REQ-008 SHALL have port next_pc_in  input  ADDR_BITS  PC+4 of instr_in.
REQ-009 SHALL have ports wb_we/wb_addr/wb_data  input  1/REG_ADDR_BITS/DATA_WIDTH  write-back port.
REQ-010 SHALL have ports ex_mem_read/ex_rt  input  1/REG_ADDR_BITS  load in EX and its destination.
REQ-011 SHALL have ports branch/branch_pc_out  output  1/ADDR_BITS  redirect to fetch (combinational).
REQ-012 SHALL have port stall  output  1  load-use hazard; fetch holds PC and instruction while high.
REQ-013 SHALL have registered ID/EX outputs rs_data_out, rt_data_out, imm_out (DATA_WIDTH), rs_out, rt_out, rd_out (REG_ADDR_BITS), ctrl_out (10: reg_write, mem_read, mem_write, mem_to_reg, alu_src, reg_dst, alu_op[3:0]).

Function
REQ-014 SHALL hold 32 registers; r0 reads 0 always; writes to r0 ignored.
REQ-015 SHALL write wb_data to wb_addr on rising clk when wb_we && enable.
REQ-016 SHALL bypass: read of rs/rt equal to nonzero wb_addr with wb_we high returns wb_data same cycle.
REQ-017 SHALL decode opcode: 0x00 R-type, 0x23 lw, 0x2B sw, 0x08 addi, 0x04 beq, 0x05 bne, 0x02 j; any other opcode yields ctrl all zero (NOP).
REQ-018 SHALL sign-extend instr_in[15:0] to imm_out.
REQ-019 SHALL assert branch for beq when bypassed rs==rt, for bne when unequal, for j always; branch is 0 when stall or !enable.
REQ-020 SHALL compute branch_pc_out = next_pc_in + (sext(imm)<<2) for beq/bne, {next_pc_in[31:28], instr_in[25:0], 2'b00} for j; arithmetic wraps modulo 2^ADDR_BITS.
REQ-021 SHALL implement one architectural delay slot: no flush of the instruction following a taken branch.
REQ-022 SHALL assert stall when ex_mem_read && ex_rt!=0 && (ex_rt==rs || (ex_rt==rt && opcode in {R-type, sw, beq, bne})).
REQ-023 SHALL, on a stall cycle with enable high, load ID/EX with ctrl_out=0 (bubble) while other ID/EX fields are don't-care.
REQ-024 SHALL, when not stalling and enable high, register decoded fields into ID/EX with latency 1 cycle.
REQ-025 SHALL treat simultaneous write-back and read of the same register per REQ-016 regardless of stall.

Reset
REQ-026 SHALL, on reset assertion, immediately clear all ID/EX outputs to 0 and all registers to 0, independent of clk.
REQ-027 SHALL resume normal operation on the first rising clk after reset deasserts; reset mid-stall drops the stall state (stall then depends only on inputs).

Structure
REQ-028 SHALL place opcode constants, ctrl_out bit positions and alu_op encodings in a shared constants header used by decode and execute stages.
REQ-029 SHALL implement the register file as sub-module reg_file (2 read, 1 write, bypass inside).

Verification
REQ-030 SHALL verify: write r5=0x0000_00AA via wb port, then addi r6,r5,1 -> rs_data_out=0xAA, imm_out=1, ctrl_out alu_src=1, reg_write=1 one cycle later.
REQ-031 SHALL verify: beq r1,r2,-1 with r1=r2=7, next_pc_in=0x100 -> branch=1, branch_pc_out=0xFC; with r2=8 -> branch=0.
REQ-032 SHALL verify: j 0x0000040 with next_pc_in=0x1000_0004 -> branch_pc_out=0x1000_0100.
REQ-033 SHALL verify: ex_mem_read=1, ex_rt=3, instr add r4,r3,r2 -> stall=1, next ctrl_out=0; ex_rt=0 -> stall=0.
REQ-034 SHALL verify: same-cycle wb_we to r9=0x55 and read of r9 -> rs_data_out=0x55; write to r0 -> r0 reads 0.
REQ-035 SHALL verify: reset asserted mid-sequence between clock edges -> all outputs 0 before next edge; enable=0 holds outputs for 3 cycles.

Source files
------------

// File: rtl/idecode_pkg.sv
// ---------------------------------------------------------------------------
// idecode_pkg
// Constants shared between the decode stage and the execute stage:
//   - primary opcode values
//   - ctrl_out bit positions and the packed ctrl_t layout
//   - alu_op encodings
//   - helpers that map an opcode to its control word and to whether it
//     consumes the rt register as a source operand.
// ---------------------------------------------------------------------------
package idecode_pkg;

    // Primary opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;

    // ctrl_out bit positions
    localparam int CTRL_W          = 10;
    localparam int CTRL_REG_WRITE  = 9;
    localparam int CTRL_MEM_READ   = 8;
    localparam int CTRL_MEM_WRITE  = 7;
    localparam int CTRL_MEM_TO_REG = 6;
    localparam int CTRL_ALU_SRC    = 5;
    localparam int CTRL_REG_DST    = 4;
    localparam int CTRL_ALU_OP_MSB = 3;
    localparam int CTRL_ALU_OP_LSB = 0;

    // alu_op encodings; ALU_FUNCT tells execute to decode the funct field
    localparam logic [3:0] ALU_ADD   = 4'h0;
    localparam logic [3:0] ALU_SUB   = 4'h1;
    localparam logic [3:0] ALU_FUNCT = 4'h2;

    // Field order matches the bit positions above (reg_write is bit 9).
    typedef struct packed {
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       alu_src;
        logic       reg_dst;
        logic [3:0] alu_op;
    } ctrl_t;

    // Opcode -> control word. Unknown opcodes (and j, which does nothing
    // downstream) produce an all-zero word, i.e. a NOP.
    function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
        ctrl_t c;
        c = '0;
        case (opcode)
            OP_RTYPE: begin
                c.reg_write = 1'b1;
                c.reg_dst   = 1'b1;
                c.alu_op    = ALU_FUNCT;
            end
            OP_LW: begin
                c.reg_write  = 1'b1;
                c.mem_read   = 1'b1;
                c.mem_to_reg = 1'b1;
                c.alu_src    = 1'b1;
                c.alu_op     = ALU_ADD;
            end
            OP_SW: begin
                c.mem_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_ADD;
            end
            OP_ADDI: begin
                c.reg_write = 1'b1;
                c.alu_src   = 1'b1;
                c.alu_op    = ALU_ADD;
            end
            OP_BEQ, OP_BNE: begin
                c.alu_op = ALU_SUB;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    // Opcodes whose rt field is a source operand (and so can suffer a
    // load-use hazard on rt). For lw/addi rt is the destination.
    function automatic logic reads_rt(input logic [5:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_SW) ||
               (opcode == OP_BEQ)   || (opcode == OP_BNE);
    endfunction

endpackage

// File: rtl/idecode_if.sv
// ---------------------------------------------------------------------------
// idecode_if
// Bundles the decode stage's fetch-side inputs, write-back port, EX hazard
// inputs, fetch redirect outputs and registered ID/EX outputs.
//   master : the surrounding pipeline (drives fetch/wb/ex, reads results)
//   slave  : the decode stage itself
// ---------------------------------------------------------------------------
interface idecode_if
    import idecode_pkg::*;
#(
    parameter int ADDR_BITS     = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int REG_ADDR_BITS = 5
);
    // global step
    logic                     enable;
    // from fetch
    logic [DATA_WIDTH-1:0]    instr_in;
    logic [ADDR_BITS-1:0]     next_pc_in;
    // write-back port
    logic                     wb_we;
    logic [REG_ADDR_BITS-1:0] wb_addr;
    logic [DATA_WIDTH-1:0]    wb_data;
    // load currently in EX
    logic                     ex_mem_read;
    logic [REG_ADDR_BITS-1:0] ex_rt;
    // redirect / hazard back to fetch
    logic                     branch;
    logic [ADDR_BITS-1:0]     branch_pc_out;
    logic                     stall;
    // ID/EX pipeline register
    logic [DATA_WIDTH-1:0]    rs_data_out;
    logic [DATA_WIDTH-1:0]    rt_data_out;
    logic [DATA_WIDTH-1:0]    imm_out;
    logic [REG_ADDR_BITS-1:0] rs_out;
    logic [REG_ADDR_BITS-1:0] rt_out;
    logic [REG_ADDR_BITS-1:0] rd_out;
    logic [CTRL_W-1:0]        ctrl_out;

    modport master (
        output enable, instr_in, next_pc_in, wb_we, wb_addr, wb_data,
               ex_mem_read, ex_rt,
        input  branch, branch_pc_out, stall, rs_data_out, rt_data_out,
               imm_out, rs_out, rt_out, rd_out, ctrl_out
    );

    modport slave (
        input  enable, instr_in, next_pc_in, wb_we, wb_addr, wb_data,
               ex_mem_read, ex_rt,
        output branch, branch_pc_out, stall, rs_data_out, rt_data_out,
               imm_out, rs_out, rt_out, rd_out, ctrl_out
    );
endinterface

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// 2-read / 1-write register file, 2**REG_ADDR_BITS entries.
//   clk, reset           : clock, asynchronous active-high clear of all entries
//   enable               : global step; writes only happen while high
//   rd_addr_a/b, rd_data_a/b : combinational read ports
//   wr_en, wr_addr, wr_data  : write port
// r0 always reads zero and ignores writes. A read of the register being
// written in the same cycle returns the write data (write-through bypass).
// ---------------------------------------------------------------------------
module reg_file #(
    parameter int DATA_WIDTH    = 32,
    parameter int REG_ADDR_BITS = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic [REG_ADDR_BITS-1:0] rd_addr_a,
    input  logic [REG_ADDR_BITS-1:0] rd_addr_b,
    output logic [DATA_WIDTH-1:0]    rd_data_a,
    output logic [DATA_WIDTH-1:0]    rd_data_b,
    input  logic                     wr_en,
    input  logic [REG_ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data
);
    localparam int NUM_REGS = 1 << REG_ADDR_BITS;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  wr_live;

    // A write to r0 is not a write at all, neither for storage nor bypass.
    assign wr_live = wr_en && (wr_addr != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_live && enable) begin
            regs[wr_addr] <= wr_data;
        end
    end

    // Bypass does not look at enable: the value on the write port is what
    // the register will hold, so a same-cycle reader sees it either way.
    always_comb begin
        rd_data_a = regs[rd_addr_a];
        if (rd_addr_a == '0) begin
            rd_data_a = '0;
        end else if (wr_live && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
        end
    end

    always_comb begin
        rd_data_b = regs[rd_addr_b];
        if (rd_addr_b == '0) begin
            rd_data_b = '0;
        end else if (wr_live && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
        end
    end

endmodule

// File: rtl/idecode.sv
// ---------------------------------------------------------------------------
// idecode
// Instruction decode stage of a 5-stage MIPS-like pipeline.
//   clk   : rising-edge clock
//   reset : asynchronous active-high; clears ID/EX and the register file
//   bus   : idecode_if.slave
//     enable                  global step, low freezes all state
//     instr_in, next_pc_in    instruction from fetch and its PC+4
//     wb_we/wb_addr/wb_data   write-back port into the register file
//     ex_mem_read, ex_rt      load in EX, used for load-use detection
//     branch, branch_pc_out   combinational redirect to fetch
//     stall                   load-use hazard, fetch holds while high
//     rs/rt_data_out, imm_out, rs/rt/rd_out, ctrl_out   ID/EX register
// Branches resolve here with one delay slot: the instruction behind a taken
// branch is never flushed.
// ---------------------------------------------------------------------------
module idecode
    import idecode_pkg::*;
#(
    parameter int ADDR_BITS     = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int REG_ADDR_BITS = 5
) (
    input logic      clk,
    input logic      reset,
    idecode_if.slave bus
);
    // ---- stage p0: field extraction, register read, hazard, branch ----
    logic [5:0]                   opcode_p0;
    logic [REG_ADDR_BITS-1:0]     rs_p0;
    logic [REG_ADDR_BITS-1:0]     rt_p0;
    logic [REG_ADDR_BITS-1:0]     rd_p0;
    logic signed [DATA_WIDTH-1:0] imm_p0;
    logic [DATA_WIDTH-1:0]        rs_data_p0;
    logic [DATA_WIDTH-1:0]        rt_data_p0;
    logic                         stall_p0;
    logic                         taken_p0;
    logic signed [ADDR_BITS-1:0]  br_off_p0;
    logic [ADDR_BITS-1:0]         br_pc_p0;
    logic [ADDR_BITS-1:0]         j_pc_p0;

    assign opcode_p0 = bus.instr_in[31:26];
    assign rs_p0     = bus.instr_in[21 +: REG_ADDR_BITS];
    assign rt_p0     = bus.instr_in[16 +: REG_ADDR_BITS];
    assign rd_p0     = bus.instr_in[11 +: REG_ADDR_BITS];
    assign imm_p0    = {{(DATA_WIDTH-16){bus.instr_in[15]}}, bus.instr_in[15:0]};

    reg_file #(
        .DATA_WIDTH    (DATA_WIDTH),
        .REG_ADDR_BITS (REG_ADDR_BITS)
    ) u_reg_file (
        .clk       (clk),
        .reset     (reset),
        .enable    (bus.enable),
        .rd_addr_a (rs_p0),
        .rd_addr_b (rt_p0),
        .rd_data_a (rs_data_p0),
        .rd_data_b (rt_data_p0),
        .wr_en     (bus.wb_we),
        .wr_addr   (bus.wb_addr),
        .wr_data   (bus.wb_data)
    );

    // Load-use: the loaded value is not available until after MEM, so any
    // source operand matching the load's destination must wait a cycle.
    assign stall_p0 = bus.ex_mem_read && (bus.ex_rt != '0) &&
                      ((bus.ex_rt == rs_p0) ||
                       ((bus.ex_rt == rt_p0) && reads_rt(opcode_p0)));

    always_comb begin
        taken_p0 = 1'b0;
        case (opcode_p0)
            OP_BEQ:  taken_p0 = (rs_data_p0 == rt_data_p0);
            OP_BNE:  taken_p0 = (rs_data_p0 != rt_data_p0);
            OP_J:    taken_p0 = 1'b1;
            default: taken_p0 = 1'b0;
        endcase
    end

    // Word offset scaled to bytes; the add wraps at ADDR_BITS.
    assign br_off_p0 = {{(ADDR_BITS-18){bus.instr_in[15]}}, bus.instr_in[15:0], 2'b00};
    assign br_pc_p0  = bus.next_pc_in + $unsigned(br_off_p0);
    assign j_pc_p0   = {bus.next_pc_in[ADDR_BITS-1:28], bus.instr_in[25:0], 2'b00};

    assign bus.stall         = stall_p0;
    assign bus.branch        = taken_p0 && !stall_p0 && bus.enable;
    assign bus.branch_pc_out = (opcode_p0 == OP_J) ? j_pc_p0 : br_pc_p0;

    // ---- stage p1: ID/EX pipeline register ----
    ctrl_t                    ctrl_p1;
    logic [DATA_WIDTH-1:0]    rs_data_p1;
    logic [DATA_WIDTH-1:0]    rt_data_p1;
    logic [DATA_WIDTH-1:0]    imm_p1;
    logic [REG_ADDR_BITS-1:0] rs_p1;
    logic [REG_ADDR_BITS-1:0] rt_p1;
    logic [REG_ADDR_BITS-1:0] rd_p1;

    // On a stall only ctrl is forced to zero (the bubble); the data fields
    // still load, since nothing downstream acts on them without ctrl bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_p1    <= '0;
            rs_data_p1 <= '0;
            rt_data_p1 <= '0;
            imm_p1     <= '0;
            rs_p1      <= '0;
            rt_p1      <= '0;
            rd_p1      <= '0;
        end else if (bus.enable) begin
            ctrl_p1    <= stall_p0 ? ctrl_t'('0) : decode_ctrl(opcode_p0);
            rs_data_p1 <= rs_data_p0;
            rt_data_p1 <= rt_data_p0;
            imm_p1     <= $unsigned(imm_p0);
            rs_p1      <= rs_p0;
            rt_p1      <= rt_p0;
            rd_p1      <= rd_p0;
        end
    end

    assign bus.ctrl_out    = ctrl_p1;
    assign bus.rs_data_out = rs_data_p1;
    assign bus.rt_data_out = rt_data_p1;
    assign bus.imm_out     = imm_p1;
    assign bus.rs_out      = rs_p1;
    assign bus.rt_out      = rt_p1;
    assign bus.rd_out      = rd_p1;

endmodule
